axis_histogram_sequencer: RTL and testbench
===========================================

Name: axis_histogram_sequencer

Overview:
Run controller for the AXI-Stream histogram accumulator. It clears the histogram, then gates the sample stream into it for a programmed dwell time and/or event count, or until a software stop. After the last BRAM update drains it reports done, with elapsed-cycle and accepted-event counts. It sits between the ADC/peak-detect stream and the histogram core, and drives that core's active-low reset.

Parameters:
AXIS_TDATA_WIDTH, 16, sample/bin-address stream width
CNTR_WIDTH, 32, width of dwell-time and event counters
BRAM_ADDR_WIDTH, 14, histogram address width; sets clear duration

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
cfg_start  in  1  level; rising edge (internally registered) starts a run
cfg_stop  in  1  level; high during RUN ends the run
cfg_time  in  CNTR_WIDTH  dwell in RUN cycles; 0 = unlimited
cfg_events  in  CNTR_WIDTH  event limit; 0 = unlimited
sts_state  out  2  0 IDLE, 1 CLEAR, 2 RUN, 3 DRAIN/DONE (sts_done distinguishes)
sts_done  out  1  high in DONE
sts_time  out  CNTR_WIDTH  RUN cycles elapsed
sts_events  out  CNTR_WIDTH  accepted events
hist_aresetn  out  1  reset to histogram core
s_axis_tdata  in  AXIS_TDATA_WIDTH  input samples
s_axis_tvalid  in  1
s_axis_tready  out  1
m_axis_tdata  out  AXIS_TDATA_WIDTH  to histogram
m_axis_tvalid  out  1
m_axis_tready  in  1

Behaviour:
- Reset (async, areset=1): state IDLE, sts_done=0, sts_time=0, sts_events=0, hist_aresetn=0, start edge register cleared. hist_aresetn goes 1 on the first clock after release.
- m_axis_tdata = s_axis_tdata always, combinational.
- In RUN: m_axis_tvalid = s_axis_tvalid and s_axis_tready = m_axis_tready, combinational pass-through.
- Outside RUN: m_axis_tvalid=0 and s_axis_tready=1. Samples are discarded; the source is never back-pressured.
- The start edge is detected when cfg_start is 1 and was 0 on the previous clock.
- IDLE or DONE + start edge -> CLEAR. On entry, sts_time, sts_events and sts_done are zeroed and the clear counter is set to 0.
- Start edges in CLEAR, RUN or DRAIN are ignored.
- CLEAR lasts exactly 2^BRAM_ADDR_WIDTH+4 cycles, counted by an internal counter of width BRAM_ADDR_WIDTH+1.
  - hist_aresetn=0 (registered) during the first 2 CLEAR cycles, 1 otherwise.
  - cfg_stop is ignored in CLEAR.
  - Then -> RUN.
- RUN, every cycle:
  - sts_time increments by 1.
  - A handshake is m_axis_tvalid & m_axis_tready. On a handshake sts_events increments, saturating at all-ones.
  - Exit to DRAIN next cycle if any of the following holds in the current cycle:
    - (cfg_time!=0 and sts_time+1 == cfg_time)
    - (cfg_events!=0 and a handshake occurs and sts_events+1 == cfg_events)
    - cfg_stop==1
  - Consequence: cfg_time=N gives exactly N RUN cycles, and a handshake in the exit cycle is counted and forwarded.
  - sts_time saturates at all-ones when cfg_time=0.
  - cfg_time and cfg_events are sampled live; lowering either below the current count is ignored until the counter wraps (it saturates instead), so only cfg_stop ends the run.
- DRAIN: gating is already off.
  - Wait for m_axis_tready==1, meaning the histogram has finished its read-modify-write.
  - Then -> DONE and sts_done=1.
  - DRAIN lasts at least 1 cycle; at most 3 cycles against the histogram core.
- DONE holds all counters until a start edge.
- sts_state is 0 in IDLE, 1 in CLEAR, 2 in RUN, 3 in DRAIN and DONE.
- All status outputs are registered.
- Reset mid-run: immediate return to IDLE. hist_aresetn low for the reset duration, so the histogram re-clears.

Test Plan:
- BRAM_ADDR_WIDTH=4. Start edge in IDLE -> sts_state=1 for exactly 20 cycles; hist_aresetn low for cycles 1-2 of CLEAR; s_axis_tready=1 and m_axis_tvalid=0 throughout.
- cfg_time=100, cfg_events=0, tvalid held 1, histogram-model tready high 1-in-4 -> exactly 100 RUN cycles; sts_time=100; sts_events=25 (±1 by phase); DONE after tready returns.
- cfg_time=0, cfg_events=5, continuous valid -> exactly 5 forwarded handshakes; m_axis_tvalid=0 from the cycle after the 5th; sts_events=5; sts_done=1.
- cfg_time=0, cfg_events=0, assert cfg_stop after 37 RUN cycles -> sts_time=37; RUN ends next cycle; DONE reached once tready=1.
- Start held high through DONE -> no restart; drop then raise start -> new CLEAR with counters zeroed.
- areset asserted mid-RUN, asynchronously between edges -> outputs immediately IDLE-valued, counters 0, hist_aresetn=0; after release, a new start runs normally.

Source files
------------

// File: rtl/axis_histogram_sequencer.sv
// Run controller for the AXI-Stream histogram accumulator: clear, gated run,
// drain, done; exposes elapsed-cycle and accepted-event counts.
module axis_histogram_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int CNTR_WIDTH       = 32,
  parameter int BRAM_ADDR_WIDTH  = 14
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_start,
  input  logic                        cfg_stop,
  input  logic [CNTR_WIDTH-1:0]       cfg_time,
  input  logic [CNTR_WIDTH-1:0]       cfg_events,
  output logic [1:0]                  sts_state,
  output logic                        sts_done,
  output logic [CNTR_WIDTH-1:0]       sts_time,
  output logic [CNTR_WIDTH-1:0]       sts_events,
  output logic                        hist_aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Clear runs 2^BRAM_ADDR_WIDTH + 4 cycles: counter values 0 .. CLEAR_LAST.
  localparam logic [BRAM_ADDR_WIDTH:0] CLEAR_LAST =
    (BRAM_ADDR_WIDTH+1)'((2 ** BRAM_ADDR_WIDTH) + 3);

  state_t                    state;
  state_t                    state_nxt;
  logic                      start_q;
  logic                      start_edge;
  logic                      handshake;
  logic                      time_hit;
  logic                      events_hit;
  logic                      run_exit;
  logic [BRAM_ADDR_WIDTH:0]  clear_cnt;
  logic [CNTR_WIDTH-1:0]     time_inc;
  logic [CNTR_WIDTH-1:0]     events_inc;

  assign start_edge = cfg_start & ~start_q;
  assign handshake  = m_axis_tvalid & m_axis_tready;
  assign time_inc   = sts_time + CNTR_WIDTH'(1);
  assign events_inc = sts_events + CNTR_WIDTH'(1);
  assign time_hit   = (cfg_time != '0) && (time_inc == cfg_time);
  assign events_hit = (cfg_events != '0) && handshake && (events_inc == cfg_events);
  assign run_exit   = time_hit | events_hit | cfg_stop;

  assign m_axis_tdata = s_axis_tdata;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_edge) state_nxt = S_CLEAR;
      S_CLEAR: if (clear_cnt == CLEAR_LAST) state_nxt = S_RUN;
      S_RUN:   if (run_exit) state_nxt = S_DRAIN;
      S_DRAIN: if (m_axis_tready) state_nxt = S_DONE;
      S_DONE:  if (start_edge) state_nxt = S_CLEAR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b1;
    sts_state     = 2'd0;
    case (state)
      S_IDLE:  sts_state = 2'd0;
      S_CLEAR: sts_state = 2'd1;
      S_RUN: begin
        sts_state     = 2'd2;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
      end
      S_DRAIN: sts_state = 2'd3;
      S_DONE:  sts_state = 2'd3;
      default: sts_state = 2'd0;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      start_q      <= 1'b0;
      clear_cnt    <= '0;
      sts_done     <= 1'b0;
      sts_time     <= '0;
      sts_events   <= '0;
      hist_aresetn <= 1'b0;
    end else begin
      start_q <= cfg_start;

      // Histogram reset is low for the first two clear cycles only.
      if (((state == S_IDLE) || (state == S_DONE)) && start_edge) begin
        hist_aresetn <= 1'b0;
      end else if ((state == S_CLEAR) && (clear_cnt == '0)) begin
        hist_aresetn <= 1'b0;
      end else begin
        hist_aresetn <= 1'b1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start_edge) begin
            clear_cnt  <= '0;
            sts_done   <= 1'b0;
            sts_time   <= '0;
            sts_events <= '0;
          end
        end
        S_CLEAR: begin
          clear_cnt <= clear_cnt + (BRAM_ADDR_WIDTH+1)'(1);
        end
        S_RUN: begin
          if (sts_time != '1) sts_time <= time_inc;
          if (handshake && (sts_events != '1)) sts_events <= events_inc;
        end
        S_DRAIN: begin
          if (m_axis_tready) sts_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_histogram_sequencer.sv
// Directed bench for axis_histogram_sequencer with a small histogram (16 bins).
module tb_axis_histogram_sequencer;

  localparam int AW = 4;
  localparam int CW = 32;
  localparam int DW = 16;
  localparam int CLEAR_CYC = (2 ** AW) + 4;

  logic          aclk;
  logic          areset;
  logic          cfg_start;
  logic          cfg_stop;
  logic [CW-1:0] cfg_time;
  logic [CW-1:0] cfg_events;
  logic [1:0]    sts_state;
  logic          sts_done;
  logic [CW-1:0] sts_time;
  logic [CW-1:0] sts_events;
  logic          hist_aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;

  axis_histogram_sequencer #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH(CW),
    .BRAM_ADDR_WIDTH(AW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_start(cfg_start),
    .cfg_stop(cfg_stop),
    .cfg_time(cfg_time),
    .cfg_events(cfg_events),
    .sts_state(sts_state),
    .sts_done(sts_done),
    .sts_time(sts_time),
    .sts_events(sts_events),
    .hist_aresetn(hist_aresetn),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int tready_mode = 1;   // 0: always ready, 1: ready 1-in-4, 2: never ready
  int hs_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Histogram-core ready model
  initial begin
    int ph;
    ph = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      case (tready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ((ph % 4) == 0);
        default: m_axis_tready = 1'b0;
      endcase
      ph++;
    end
  end

  // Forwarded handshakes, sampled just before each rising edge
  initial begin
    forever begin
      @(negedge aclk);
      #4;
      if ((m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b1)) hs_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic count_state(input logic [1:0] s, input int maxc, output int n);
    n = 0;
    while ((sts_state == s) && (n < maxc)) begin
      n++;
      @(negedge aclk);
    end
  endtask

  task automatic wait_done(input int maxc, output int k);
    k = 0;
    while ((sts_done !== 1'b1) && (k < maxc)) begin
      k++;
      @(negedge aclk);
    end
  endtask

  initial begin
    int n;
    int k;
    int hs0;

    areset        = 1'b1;
    cfg_start     = 1'b0;
    cfg_stop      = 1'b0;
    cfg_time      = 100;
    cfg_events    = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'hA5C3;

    repeat (3) @(negedge aclk);
    check("rst_state", sts_state, 0);
    check("rst_done", sts_done, 0);
    check("rst_time", sts_time, 0);
    check("rst_events", sts_events, 0);
    check("rst_hist_aresetn", hist_aresetn, 0);
    check("rst_s_tready", s_axis_tready, 1);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("tdata_pass", m_axis_tdata, 16'hA5C3);

    areset = 1'b0;
    @(negedge aclk);
    check("rel_hist_aresetn", hist_aresetn, 1);
    check("rel_state", sts_state, 0);

    // Clear phase timing, then a 100-cycle dwell with sparse ready
    cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    n = 0;
    while ((sts_state == 2'd1) && (n < 100)) begin
      n++;
      check("clr_hist_aresetn", hist_aresetn, (n <= 2) ? 1'b0 : 1'b1);
      check("clr_s_tready", s_axis_tready, 1);
      check("clr_m_tvalid", m_axis_tvalid, 0);
      @(negedge aclk);
    end
    check("clr_cycles", n, CLEAR_CYC);

    hs0 = hs_cnt;
    count_state(2'd2, 1000, n);
    check("t_run_cycles", n, 100);
    check("t_drain_state", sts_state, 3);
    check("t_drain_m_tvalid", m_axis_tvalid, 0);
    wait_done(10, k);
    check("t_done", sts_done, 1);
    check("t_drain_len", ((k >= 1) && (k <= 4)), 1);
    check("t_time", sts_time, 100);
    check("t_events_range", ((sts_events >= 24) && (sts_events <= 26)), 1);
    check("t_events_vs_fwd", sts_events, hs_cnt - hs0);

    // Event-limited run with continuous handshakes
    tready_mode = 0;
    cfg_time    = 0;
    cfg_events  = 5;
    cfg_start   = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    check("e_restart_state", sts_state, 1);
    check("e_restart_time", sts_time, 0);
    check("e_restart_events", sts_events, 0);
    check("e_restart_done", sts_done, 0);
    count_state(2'd1, 100, n);
    check("e_clr_cycles", n, CLEAR_CYC);
    hs0 = hs_cnt;
    count_state(2'd2, 100, n);
    check("e_run_cycles", n, 5);
    check("e_m_tvalid_off", m_axis_tvalid, 0);
    check("e_fwd_hs", hs_cnt - hs0, 5);
    wait_done(10, k);
    check("e_done", sts_done, 1);
    check("e_drain_len", k, 1);
    check("e_events", sts_events, 5);
    check("e_time", sts_time, 5);

    // Software stop after 37 cycles; start held high throughout
    tready_mode = 2;
    cfg_events  = 0;
    cfg_start   = 1'b1;
    @(negedge aclk);
    count_state(2'd1, 100, n);
    check("s_clr_cycles", n, CLEAR_CYC);
    n = 0;
    while ((sts_state == 2'd2) && (n < 1000)) begin
      n++;
      if (n == 37) cfg_stop = 1'b1;
      @(negedge aclk);
    end
    cfg_stop = 1'b0;
    check("s_run_cycles", n, 37);
    check("s_drain_state", sts_state, 3);
    check("s_drain_not_done", sts_done, 0);
    repeat (3) @(negedge aclk);
    check("s_drain_wait_state", sts_state, 3);
    check("s_drain_wait_done", sts_done, 0);
    tready_mode = 0;
    wait_done(10, k);
    check("s_done", sts_done, 1);
    check("s_time", sts_time, 37);
    check("s_events", sts_events, 0);
    repeat (5) @(negedge aclk);
    check("s_hold_state", sts_state, 3);
    check("s_hold_done", sts_done, 1);
    check("s_hold_time", sts_time, 37);
    cfg_start = 1'b0;
    @(negedge aclk);
    cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    check("s_new_clear", sts_state, 1);
    check("s_new_time", sts_time, 0);
    check("s_new_done", sts_done, 0);

    // Asynchronous reset in the middle of a run
    count_state(2'd1, 100, n);
    check("r_clr_cycles", n, CLEAR_CYC);
    repeat (10) @(negedge aclk);
    check("r_in_run", sts_state, 2);
    #2;
    areset = 1'b1;
    #1;
    check("r_state", sts_state, 0);
    check("r_time", sts_time, 0);
    check("r_events", sts_events, 0);
    check("r_done", sts_done, 0);
    check("r_hist_aresetn", hist_aresetn, 0);
    check("r_m_tvalid", m_axis_tvalid, 0);
    check("r_s_tready", s_axis_tready, 1);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("r_rel_hist_aresetn", hist_aresetn, 1);
    check("r_rel_state", sts_state, 0);
    cfg_time  = 3;
    cfg_start = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    count_state(2'd1, 100, n);
    check("r2_clr_cycles", n, CLEAR_CYC);
    count_state(2'd2, 100, n);
    check("r2_run_cycles", n, 3);
    wait_done(10, k);
    check("r2_done", sts_done, 1);
    check("r2_time", sts_time, 3);
    check("r2_events", sts_events, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
